bcd_to_binary: RTL and testbench
================================

# bcd_to_binary

Sequential converter from a 4-digit packed BCD value (0000–9999) to a 16-bit unsigned binary value. It is the inverse of the display path's binary-to-BCD conversion, and serves blocks that receive decimal operands, such as keypad entry or BCD register readback, and need them in binary. Conversion uses reverse double-dabble: 16 shift/correct iterations, fixed latency, with a start/busy/done handshake.

## Interface
- CHECK_DIGITS, default 1: when 1, any nibble > 9 at capture flags an error. When 0, nibbles are not checked and the result for out-of-range digits is don't-care.
- sys_clk  in  1  system clock (25 MHz); all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only while idle.
- bcd_in  in  16  packed BCD {d3,d2,d1,d0}, d0 = least significant; sampled on the accepting edge only.
- bin_out  out  16  converted value; holds until the next completion.
- busy  out  1  high while a conversion is in progress.
- done  out  1  one-cycle pulse when bin_out/err are updated.
- err  out  1  invalid-digit flag for the most recent conversion; holds with bin_out.

## Operation
- One clock, sys_clk. Reset is synchronous and active-high.
- States:
  - IDLE: busy=0. If start=1, capture bcd_in into the 16-bit digit register, clear the 16-bit binary shift register, set cnt=0 and latch bad = (CHECK_DIGITS and any nibble > 9), then go to SHIFT.
  - SHIFT: busy=1. Each cycle, shift the 32-bit {digits, binary} right by one bit (digit LSB enters binary MSB). Then, in each of the four 4-bit digit fields, subtract 3 from any digit ≥ 8 (independent per digit, same cycle). cnt increments each cycle. After the cycle with cnt=15, go to FINISH.
  - FINISH: bin_out ← bad ? 16'hFFFF : binary register. err ← bad. done=1 for this one cycle. Return to IDLE.
- Arithmetic:
  - Valid inputs give results ≤ 9999 (16'h270F), so bits 15:14 are always 0 on valid results.
  - Digit correction never underflows, because a digit ≥ 8 minus 3 stays ≥ 5.
- Invalid digits do not shorten the conversion. Latency is constant whether the input is valid or not.
- start while busy is ignored, not queued. bcd_in changes during SHIFT have no effect.
- start may be held high continuously; a new conversion begins on each IDLE cycle, giving back-to-back operation.
- Reset at any point, including mid-SHIFT: next state IDLE, busy=0, done=0, err=0, bin_out=0, cnt=0, and internal registers cleared. An aborted conversion produces no done pulse.
- If reset and start are high on the same edge, reset wins and the start is lost.

## Timing
- Reset values: bin_out=16'h0000, busy=0, done=0, err=0.
- Let E0 be the edge that samples start=1 in IDLE.
  - busy=1 from after E0 through E17.
  - E1–E16 perform the 16 shifts.
  - E17 (the FINISH edge) drives busy=0, done=1, and updates bin_out/err.
  - done deasserts after E18.
- Start-to-done latency is 17 cycles. bin_out is valid in the same cycle done is high, and stays stable afterward.
- Throughput: one conversion per 18 cycles with start held high, since the next start is sampled in the IDLE cycle after FINISH.
- busy and done are never high in the same cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset, then start with bcd_in=16'h0000 → done 17 cycles after the start edge; bin_out=16'h0000, err=0.
- bcd_in=16'h1234 → bin_out=16'h04D2, err=0. bcd_in=16'h9999 → bin_out=16'h270F. bcd_in=16'h0001 → 16'h0001.
- CHECK_DIGITS=1 and bcd_in=16'h00A5 → after 17 cycles, done=1, bin_out=16'hFFFF, err=1. A following 16'h0042 → bin_out=16'h002A, err=0.
- Start pulsed again at cycles 3 and 10 of a 16'h0500 conversion with bcd_in changed to 16'h7777 → single done, bin_out=16'h01F4; no second done.
- Reset asserted during the 8th shift of 16'h4321 → busy=0 next cycle, no done, bin_out=0. Then 16'h0100 → bin_out=16'h0064.
- start held high across 16'h0010, 16'h0250, 16'h9000 (changing bcd_in each IDLE cycle) → done pulses 18 cycles apart; bin_out = 16'h000A, 16'h00FA, 16'h2328. Compare against a reference model on 1000 random valid inputs.

Source files
------------

// File: rtl/bcd_to_binary_if.sv
// Handshake and data bundle between a BCD producer and the bcd_to_binary converter.
interface bcd_to_binary_if;
    logic        start;
    logic [15:0] bcd_in;
    logic [15:0] bin_out;
    logic        busy;
    logic        done;
    logic        err;

    modport master (
        output start,
        output bcd_in,
        input  bin_out,
        input  busy,
        input  done,
        input  err
    );

    modport slave (
        input  start,
        input  bcd_in,
        output bin_out,
        output busy,
        output done,
        output err
    );
endinterface

// File: rtl/bcd_to_binary.sv
// Four-digit packed BCD to 16-bit binary converter using reverse double-dabble:
// 16 shift/correct iterations with a fixed 17-cycle start-to-done latency.
module bcd_to_binary #(
    parameter bit CHECK_DIGITS = 1'b1
) (
    input  logic          sys_clk,
    input  logic          reset,
    bcd_to_binary_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t      state, state_next;
    logic [15:0] digits, digits_next;
    logic [15:0] binary, binary_next;
    logic [3:0]  cnt, cnt_next;
    logic        bad, bad_next;
    logic [15:0] bin_out_q, bin_out_next;
    logic        busy_q, busy_next;
    logic        done_q, done_next;
    logic        err_q, err_next;
    logic [31:0] shifted;

    // Each digit field that reached 8 or more after the right shift held a
    // carried-in 16 (i.e. 10 in decimal weight); subtracting 3 restores it.
    function automatic logic [15:0] correct_digits(input logic [15:0] d);
        logic [15:0] r;
        r = d;
        for (int i = 0; i < 4; i++) begin
            if (d[4*i +: 4] >= 4'd8)
                r[4*i +: 4] = d[4*i +: 4] - 4'd3;
        end
        return r;
    endfunction

    function automatic logic has_bad_digit(input logic [15:0] d);
        logic b;
        b = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (d[4*i +: 4] > 4'd9)
                b = 1'b1;
        end
        return b;
    endfunction

    always_comb begin
        state_next   = state;
        digits_next  = digits;
        binary_next  = binary;
        cnt_next     = cnt;
        bad_next     = bad;
        bin_out_next = bin_out_q;
        busy_next    = busy_q;
        done_next    = 1'b0;
        err_next     = err_q;
        shifted      = {digits, binary} >> 1;

        case (state)
            IDLE: begin
                busy_next = 1'b0;
                if (bus.start) begin
                    digits_next = bus.bcd_in;
                    binary_next = 16'h0000;
                    cnt_next    = 4'd0;
                    bad_next    = CHECK_DIGITS & has_bad_digit(bus.bcd_in);
                    busy_next   = 1'b1;
                    state_next  = SHIFT;
                end
            end
            SHIFT: begin
                digits_next = correct_digits(shifted[31:16]);
                binary_next = shifted[15:0];
                cnt_next    = cnt + 4'd1;
                if (cnt == 4'd15)
                    state_next = FINISH;
            end
            FINISH: begin
                bin_out_next = bad ? 16'hFFFF : binary;
                err_next     = bad;
                done_next    = 1'b1;
                busy_next    = 1'b0;
                state_next   = IDLE;
            end
            default: begin
                busy_next  = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state     <= IDLE;
            digits    <= 16'h0000;
            binary    <= 16'h0000;
            cnt       <= 4'd0;
            bad       <= 1'b0;
            bin_out_q <= 16'h0000;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state     <= state_next;
            digits    <= digits_next;
            binary    <= binary_next;
            cnt       <= cnt_next;
            bad       <= bad_next;
            bin_out_q <= bin_out_next;
            busy_q    <= busy_next;
            done_q    <= done_next;
            err_q     <= err_next;
        end
    end

    assign bus.bin_out = bin_out_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.err     = err_q;

endmodule

// File: tb/tb_bcd_to_binary.sv
// Directed and randomized checks of bcd_to_binary: latency, results, error flag,
// start filtering while busy, mid-conversion reset and back-to-back operation.
module tb_bcd_to_binary;

    logic sys_clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    bcd_to_binary_if bus ();

    bcd_to_binary #(.CHECK_DIGITS(1'b1)) dut (
        .sys_clk (sys_clk),
        .reset   (reset),
        .bus     (bus)
    );

    initial sys_clk = 1'b0;
    always #20 sys_clk = ~sys_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] ref_bin(input logic [15:0] bcd);
        int v;
        v = int'(bcd[15:12]) * 1000 + int'(bcd[11:8]) * 100 + int'(bcd[7:4]) * 10 + int'(bcd[3:0]);
        return 16'(v);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called just after a falling edge; leaves off at the falling edge after done drops.
    task automatic do_conv(input logic [15:0] bcd, input logic [15:0] exp_bin,
                           input logic exp_err, input string tag);
        int lat;
        bit seen;
        lat  = 0;
        seen = 1'b0;
        bus.start  = 1'b1;
        bus.bcd_in = bcd;
        for (int i = 0; i < 40; i++) begin
            @(negedge sys_clk);
            bus.start = 1'b0;
            if (i == 0) check({tag, "_busy"}, 32'(bus.busy), 32'd1);
            if (bus.done) begin
                lat  = i;
                seen = 1'b1;
                break;
            end
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        check({tag, "_latency"}, 32'(lat), 32'd17);
        check({tag, "_bin"}, 32'(bus.bin_out), 32'(exp_bin));
        check({tag, "_err"}, 32'(bus.err), 32'(exp_err));
        check({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
        @(negedge sys_clk);
        check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
        check({tag, "_bin_hold"}, 32'(bus.bin_out), 32'(exp_bin));
    endtask

    initial begin
        int          dones;
        int          k;
        logic [15:0] got;
        logic [15:0] vals [3];
        logic [15:0] exps [3];
        logic [15:0] rbcd;

        n_tests    = 0;
        n_fail     = 0;
        reset      = 1'b1;
        bus.start  = 1'b0;
        bus.bcd_in = 16'h0000;
        repeat (3) @(negedge sys_clk);
        reset = 1'b0;
        check("rst_bin", 32'(bus.bin_out), 32'h0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);

        do_conv(16'h0000, 16'h0000, 1'b0, "zero");
        do_conv(16'h1234, 16'h04D2, 1'b0, "v1234");
        do_conv(16'h9999, 16'h270F, 1'b0, "v9999");
        do_conv(16'h0001, 16'h0001, 1'b0, "v0001");
        do_conv(16'h00A5, 16'hFFFF, 1'b1, "bad00A5");
        do_conv(16'h0042, 16'h002A, 1'b0, "v0042");

        // Start pulses while busy must be ignored.
        dones      = 0;
        got        = 16'h0000;
        bus.start  = 1'b1;
        bus.bcd_in = 16'h0500;
        for (int i = 0; i < 40; i++) begin
            @(negedge sys_clk);
            if (i == 3 || i == 10) begin
                bus.start  = 1'b1;
                bus.bcd_in = 16'h7777;
            end else begin
                bus.start = 1'b0;
            end
            if (bus.done) begin
                dones++;
                got = bus.bin_out;
            end
        end
        bus.start = 1'b0;
        check("ignore_done_count", 32'(dones), 32'd1);
        check("ignore_bin", 32'(got), 32'h01F4);

        // Reset during the 8th shift aborts without a done pulse.
        bus.start  = 1'b1;
        bus.bcd_in = 16'h4321;
        for (int i = 0; i < 8; i++) begin
            @(negedge sys_clk);
            bus.start = 1'b0;
            if (i == 7) reset = 1'b1;
        end
        @(negedge sys_clk);
        reset = 1'b0;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_bin", 32'(bus.bin_out), 32'h0);
        check("abort_err", 32'(bus.err), 32'd0);
        dones = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge sys_clk);
            if (bus.done) dones++;
        end
        check("abort_no_done", 32'(dones), 32'd0);
        do_conv(16'h0100, 16'h0064, 1'b0, "v0100");

        // Reset and start on the same edge: reset wins.
        bus.start  = 1'b1;
        bus.bcd_in = 16'h0777;
        reset      = 1'b1;
        @(negedge sys_clk);
        bus.start = 1'b0;
        reset     = 1'b0;
        check("rst_start_busy", 32'(bus.busy), 32'd0);
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge sys_clk);
            if (bus.done) dones++;
        end
        check("rst_start_no_done", 32'(dones), 32'd0);

        // Back-to-back with start held high.
        vals[0] = 16'h0010; exps[0] = 16'h000A;
        vals[1] = 16'h0250; exps[1] = 16'h00FA;
        vals[2] = 16'h9000; exps[2] = 16'h2328;
        k          = 0;
        bus.start  = 1'b1;
        bus.bcd_in = vals[0];
        for (int cyc = 0; cyc < 80; cyc++) begin
            @(negedge sys_clk);
            if (bus.done) begin
                check($sformatf("b2b_bin%0d", k), 32'(bus.bin_out), 32'(exps[k]));
                check($sformatf("b2b_cycle%0d", k), 32'(cyc), 32'(17 + 18 * k));
                check($sformatf("b2b_busy%0d", k), 32'(bus.busy), 32'd0);
                k++;
                if (k == 3) begin
                    bus.start = 1'b0;
                    break;
                end
                bus.bcd_in = vals[k];
            end
        end
        bus.start = 1'b0;
        check("b2b_count", 32'(k), 32'd3);
        @(negedge sys_clk);

        for (int n = 0; n < 1000; n++) begin
            rbcd = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                    4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            do_conv(rbcd, ref_bin(rbcd), 1'b0, $sformatf("rand_%04h", rbcd));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
